// File: rtl/bram_fill_writer_pkg.sv
// Shared encodings and LFSR helpers for the block-RAM fill writer.
package bram_fill_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fill_state_e;

  typedef enum logic [1:0] {
    MODE_RAMP = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_WALK = 2'd2,
    MODE_LFSR = 2'd3
  } fill_mode_e;

  localparam logic [7:0] LFSR_TAP      = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

  // Galois right-shift step of the 8-bit pattern LFSR.
  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return d[0] ? ((d >> 1) ^ LFSR_TAP) : (d >> 1);
  endfunction

endpackage

// File: rtl/bram_fill_writer_if.sv
// Control/status and RAM write-port bundle of the fill writer.
// master: whoever requests fills; slave: the fill writer itself.
interface bram_fill_writer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  abort;
  logic                  step_en;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] seed;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output start, abort, step_en, mode, seed,
    input  w_en, w_addr, w_data, busy, done, checksum
  );

  modport slave (
    input  start, abort, step_en, mode, seed,
    output w_en, w_addr, w_data, busy, done, checksum
  );
endinterface

// File: rtl/bram_fill_pattern.sv
// Combinational pattern generator: one word for a given index.
// The LFSR word is supplied by the caller, which owns the shift register.
module bram_fill_pattern
  import bram_fill_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  fill_mode_e            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] lfsr,
  output logic [DATA_WIDTH-1:0] word
);

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] walk;

  // Select the pattern word; all arithmetic wraps at DATA_WIDTH.
  always_comb begin
    sum  = seed + DATA_WIDTH'(index);
    walk = (DATA_WIDTH'(1) << (32'(index) % DATA_WIDTH)) ^ seed;
    word = lfsr;
    unique case (mode)
      MODE_RAMP: word = sum;
      MODE_GRAY: word = sum ^ (sum >> 1);
      MODE_WALK: word = walk;
      MODE_LFSR: word = lfsr;
      default:   word = lfsr;
    endcase
  end

endmodule

// File: rtl/bram_fill_writer.sv
// Fills every RAM address with a deterministic pattern, one word per
// step tick, and publishes an XOR checksum of the completed fill.
module bram_fill_writer
  import bram_fill_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  bram_fill_writer_if.slave bus
);

  fill_state_e           state;
  fill_mode_e            mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] lfsr;
  logic [DATA_WIDTH-1:0] xor_acc;
  logic [DATA_WIDTH-1:0] word;

  logic                  w_en_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] checksum_q;

  bram_fill_pattern #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .mode  (mode_q),
    .seed  (seed_q),
    .index (idx),
    .lfsr  (lfsr),
    .word  (word)
  );

  // Fill FSM with all outputs registered; abort beats every other input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_RAMP;
      seed_q     <= '0;
      idx        <= '0;
      lfsr       <= '0;
      xor_acc    <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          w_en_q <= 1'b0;
          done_q <= 1'b0;
          if (!bus.abort && bus.start) begin
            mode_q  <= fill_mode_e'(bus.mode);
            seed_q  <= bus.seed;
            idx     <= '0;
            xor_acc <= '0;
            // All-zero is the LFSR lock-up state, so substitute a nonzero seed.
            lfsr    <= (bus.seed == '0) ? DATA_WIDTH'(LFSR_ZERO_SUB) : bus.seed;
            busy_q  <= 1'b1;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          done_q <= 1'b0;
          if (bus.abort) begin
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
            checksum_q <= '0;
            state      <= ST_IDLE;
          end else if (bus.step_en) begin
            w_en_q   <= 1'b1;
            w_addr_q <= idx;
            w_data_q <= word;
            xor_acc  <= xor_acc ^ word;
            idx      <= idx + 1'b1;
            lfsr     <= DATA_WIDTH'(lfsr_next(8'(lfsr)));
            if (&idx) state <= ST_DONE;
          end else begin
            w_en_q <= 1'b0;
          end
        end
        ST_DONE: begin
          // xor_acc already holds the last word, folded in on the final write.
          w_en_q     <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          checksum_q <= xor_acc;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.checksum = checksum_q;

endmodule

// File: tb/tb_bram_fill_writer.sv
// Directed bench for bram_fill_writer with a write scoreboard.
module tb_bram_fill_writer;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bram_fill_writer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  bram_fill_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wr_t        exp_q[$];
  logic [7:0] exp_sum;
  int checks = 0, errors = 0;
  int cyc = 0, nwr = 0, first_wen = 0, last_wen = 0, prev_wen = 0;
  int done_cnt = 0, done_cyc = 0, busy_cyc = 0;
  bit gap_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pattern straight from the pattern definitions.
  function automatic logic [7:0] model_word(input int m, input logic [7:0] s, input int i);
    logic [7:0] g, d;
    case (m)
      0: return s + 8'(i);
      1: begin g = s + 8'(i); return g ^ (g >> 1); end
      2: return (8'h01 << (i % 8)) ^ s;
      default: begin
        d = (s == 8'h00) ? 8'h01 : s;
        for (int k = 0; k < i; k++) d = d[0] ? ((d >> 1) ^ 8'hB8) : (d >> 1);
        return d;
      end
    endcase
  endfunction

  task automatic push_words(input int m, input logic [7:0] s, input int n);
    wr_t e;
    exp_sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      e.addr = 4'(i);
      e.data = model_word(m, s, i);
      exp_sum ^= e.data;
      exp_q.push_back(e);
    end
  endtask

  task automatic new_fill();
    nwr = 0; done_cnt = 0; busy_cyc = 0; gap_mode = 1'b0;
  endtask

  // One clock; sample on the falling edge and score any write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.busy) busy_cyc++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(bus.busy), 0);
      chk("wen_at_done", 32'(bus.w_en), 0);
    end
    if (bus.w_en) begin
      if (gap_mode && nwr > 0) chk("walk_gap", cyc - prev_wen, 4);
      if (nwr == 0) first_wen = cyc;
      prev_wen = cyc;
      last_wen = cyc;
      nwr++;
      chk("wen_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("w_addr", 32'(bus.w_addr), 32'(e.addr));
        chk("w_data", 32'(bus.w_data), 32'(e.data));
      end
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.step_en = 1'b0;
    bus.mode = 2'd0; bus.seed = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wen", 32'(bus.w_en), 0);
    chk("rst_addr", 32'(bus.w_addr), 0);
    chk("rst_data", 32'(bus.w_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sum", 32'(bus.checksum), 0);
    rst = 1'b1;
    tick();

    // Ramp, seed 0x10, continuous stepping.
    new_fill(); push_words(0, 8'h10, 16);
    bus.mode = 2'd0; bus.seed = 8'h10; bus.step_en = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("no_early_wen", nwr, 0);
    run_until_done(40);
    chk("ramp_nwr", nwr, 16);
    chk("ramp_consec", last_wen - first_wen, 15);
    chk("ramp_done_gap", done_cyc - last_wen, 1);
    chk("ramp_busy_cyc", busy_cyc, 17);
    chk("ramp_q_empty", exp_q.size(), 0);
    chk("ramp_sum", 32'(bus.checksum), 32'(exp_sum));
    tick();
    chk("done_pulse", 32'(bus.done), 0);

    // Walking-one, seed 0xFF, one step every 4th cycle.
    new_fill(); push_words(2, 8'hFF, 16);
    bus.mode = 2'd2; bus.seed = 8'hFF; bus.step_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    gap_mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.step_en = 1'b1; tick();
      bus.step_en = 1'b0; repeat (3) tick();
    end
    gap_mode = 1'b0;
    chk("walk_nwr", nwr, 16);
    chk("walk_done", done_cnt, 1);
    chk("walk_sum", 32'(bus.checksum), 32'(exp_sum));

    // LFSR, seed 0, start held through the fill while mode/seed change.
    new_fill(); push_words(3, 8'h00, 16);
    bus.mode = 2'd3; bus.seed = 8'h00; bus.step_en = 1'b1; bus.start = 1'b1;
    tick();
    bus.mode = 2'd0; bus.seed = 8'h55;
    run_until_done(40);
    chk("lfsr_nwr", nwr, 16);
    chk("lfsr_sum", 32'(bus.checksum), 32'(exp_sum));

    // start still high after done relaunches (ramp 0x55); abort after 5.
    new_fill(); push_words(0, 8'h55, 5);
    tick();
    bus.start = 1'b0;
    chk("relaunch_busy", 32'(bus.busy), 1);
    repeat (5) tick();
    chk("abort_pre_nwr", nwr, 5);
    bus.abort = 1'b1;
    tick();
    chk("abort_wen", 32'(bus.w_en), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_sum", 32'(bus.checksum), 0);
    bus.abort = 1'b0;
    repeat (6) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_nwr", nwr, 5);

    // start together with abort in IDLE stays idle.
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    chk("start_abort_busy", 32'(bus.busy), 0);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) tick();
    chk("start_abort_nwr", nwr, 5);

    // Ramp seed 0 after the abort, then reset mid-fill.
    new_fill(); push_words(0, 8'h00, 16);
    bus.mode = 2'd0; bus.seed = 8'h00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_nwr", nwr, 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(bus.w_en), 0);
    chk("mid_rst_addr", 32'(bus.w_addr), 0);
    chk("mid_rst_data", 32'(bus.w_data), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_sum", 32'(bus.checksum), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Gray, seed 0, with a stray start pulse mid-fill.
    new_fill(); push_words(1, 8'h00, 16);
    bus.mode = 2'd1; bus.seed = 8'h00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_until_done(40);
    chk("gray_nwr", nwr, 16);
    chk("gray_q_empty", exp_q.size(), 0);
    chk("gray_sum", 32'(bus.checksum), 32'(exp_sum));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
